// File: rtl/bit_manip_seq.sv
// bit_manip_seq: sequential bit-manipulation engine.
// Accepts one operand plus an op code (popcount, leading-zero count,
// trailing-zero count, bit reverse), scans it one bit per clock and returns
// the result with zero/parity flags over a valid/ready handshake.
// Optional feature macro: BIT_MANIP_EARLY_EXIT_EN (early termination of
// popcount/LZC/TZC scans; results are unchanged, only latency shrinks).
module bit_manip_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_parity
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   shift_reg, shift_next;
  logic [WIDTH-1:0]   result_reg, result_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [1:0]         op_reg, op_next;
  logic               found_reg, found_next;
  logic               zero_reg, zero_next;
  logic               parity_reg, parity_next;
  logic               early_done;

  // Handshake and result outputs come straight from state and registers.
  assign in_ready   = (state_reg == IDLE) && !rst;
  assign out_valid  = (state_reg == DONE);
  assign out_data   = result_reg;
  assign out_zero   = zero_reg;
  assign out_parity = parity_reg;

  // State and datapath registers; reset aborts any scan in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      result_reg <= '0;
      cnt_reg    <= '0;
      op_reg     <= 2'd0;
      found_reg  <= 1'b0;
      zero_reg   <= 1'b0;
      parity_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      result_reg <= result_next;
      cnt_reg    <= cnt_next;
      op_reg     <= op_next;
      found_reg  <= found_next;
      zero_reg   <= zero_next;
      parity_reg <= parity_next;
    end
  end

  // Next-state and per-bit processing: one operand bit consumed per BUSY cycle.
  always_comb begin
    state_next  = state_reg;
    shift_next  = shift_reg;
    result_next = result_reg;
    cnt_next    = cnt_reg;
    op_next     = op_reg;
    found_next  = found_reg;
    zero_next   = zero_reg;
    parity_next = parity_reg;
    early_done  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (in_valid && in_ready) begin
          shift_next  = in_data;
          op_next     = in_op;
          zero_next   = ~|in_data;
          parity_next = ^in_data;
          cnt_next    = '0;
          result_next = '0;
          found_next  = 1'b0;
          state_next  = BUSY;
        end
      end

      BUSY: begin
        cnt_next = cnt_reg + 1'b1;
        case (op_reg)
          2'd0: begin
            // popcount: add the LSB, then shift it out
            shift_next = shift_reg >> 1;
            if (shift_reg[0]) begin
              result_next = result_reg + 1'b1;
            end
`ifdef BIT_MANIP_EARLY_EXIT_EN
            // no set bits remain, so the count is final
            if (shift_next == '0) begin
              early_done = 1'b1;
            end
`endif
          end
          2'd1: begin
            // leading-zero count: scan from the MSB, freeze at the first 1
            shift_next = shift_reg << 1;
            if (!found_reg) begin
              if (shift_reg[WIDTH-1]) begin
                found_next = 1'b1;
`ifdef BIT_MANIP_EARLY_EXIT_EN
                early_done = 1'b1;
`endif
              end else begin
                result_next = result_reg + 1'b1;
              end
            end
          end
          2'd2: begin
            // trailing-zero count: scan from the LSB, freeze at the first 1
            shift_next = shift_reg >> 1;
            if (!found_reg) begin
              if (shift_reg[0]) begin
                found_next = 1'b1;
`ifdef BIT_MANIP_EARLY_EXIT_EN
                early_done = 1'b1;
`endif
              end else begin
                result_next = result_reg + 1'b1;
              end
            end
          end
          default: begin
            // reverse: LSB-first bits enter the result from the bottom
            result_next = {result_reg[WIDTH-2:0], shift_reg[0]};
            shift_next  = shift_reg >> 1;
          end
        endcase
        if ((cnt_reg == LAST_BIT) || early_done) begin
          state_next = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
